// File: rtl/axis_collector.sv
// axis_collector: merges NUM_CH AXI-Stream channels into one stream, packet-granular round-robin.
// Optional idle-beat watchdog is compiled in when AXIS_COLLECTOR_TIMEOUT_EN is defined.
module axis_collector #(
  parameter int NUM_CH      = 16,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        channel_enable,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [3:0]               m_axis_tuser,
  input  logic                     m_axis_tready,
  output logic [NUM_CH-1:0]        timeout_flag
);

  // state  | meaning
  // IDLE   | no grant; arbitrate among enabled requesters this cycle
  // LOCKED | grant owns the input side until a tlast beat (or watchdog close)
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [3:0]  grant, grant_nxt;
  logic [3:0]  pick;
  logic        pick_vld;
  logic [NUM_CH-1:0] enable_q;
  logic [NUM_CH-1:0] req;

  logic [1:0]  fifo_cnt;
  logic        wr_ptr, rd_ptr;
  logic [1:0][DATA_W-1:0] mem_data;
  logic [1:0][3:0]        mem_user;
  logic [1:0]             mem_last;

  logic              room, accept, push, pop;
  logic              sel_last, push_last;
  logic [DATA_W-1:0] sel_data, push_data;
  logic              to_hit, to_push;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) enable_q <= '0;
    else       enable_q <= channel_enable;
  end

  assign req = s_axis_tvalid & enable_q;

  // grant also serves as last_grant; it keeps its value through IDLE
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!pick_vld && req[(int'(grant) + i) % NUM_CH]) begin
        pick_vld = 1'b1;
        pick     = 4'((int'(grant) + i) % NUM_CH);
      end
    end
  end

  assign room     = (fifo_cnt != 2'd2);
  assign sel_data = s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
  assign sel_last = s_axis_tlast[grant];

  // ready depends only on registered state, never on m_axis_tready
  always_comb begin
    s_axis_tready = '0;
    if (state == LOCKED && room && !to_hit) s_axis_tready[grant] = 1'b1;
  end

  assign accept    = |(s_axis_tready & s_axis_tvalid);
  assign push      = accept | to_push;
  assign push_data = to_push ? '0 : sel_data;
  assign push_last = to_push ? 1'b1 : sel_last;
  assign pop       = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      grant <= 4'(NUM_CH - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if ((accept && sel_last) || to_push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AXIS_COLLECTOR_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign to_hit  = (state == LOCKED) && (idle_cnt == 16'(TIMEOUT_CYC));
  assign to_push = to_hit && room;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt     <= '0;
      timeout_flag <= '0;
    end else begin
      if (state != LOCKED || accept)
        idle_cnt <= '0;
      else if (!s_axis_tvalid[grant] && !to_hit)
        idle_cnt <= idle_cnt + 16'd1;
      if (to_push) timeout_flag[grant] <= 1'b1;
    end
  end
`else
  assign to_hit       = 1'b0;
  assign to_push      = 1'b0;
  assign timeout_flag = '0;
`endif

  // 2-entry output FIFO; head drives m_axis directly
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_data <= '0;
      mem_user <= '0;
      mem_last <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_user[wr_ptr] <= grant;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign m_axis_tvalid = (fifo_cnt != 2'd0);
  assign m_axis_tdata  = mem_data[rd_ptr];
  assign m_axis_tuser  = mem_user[rd_ptr];
  assign m_axis_tlast  = mem_last[rd_ptr];

endmodule

// File: doc/axis_collector.md
# axis_collector

Merges up to 16 per-channel AXI-Stream outputs into one stream toward the PS, the return-path counterpart of the PS-to-channel selector. Channels are arbitrated round-robin at packet granularity: a granted channel keeps the output until it delivers a beat with `tlast`. The source channel index travels on `m_axis_tuser`. A 2-entry output buffer sustains one beat per cycle and fully decouples `m_axis_tready` from the channel-side ready lines.

## Interface
- `NUM_CH`, 16: number of channel inputs; legal range 2..16.
- `DATA_W`, 256: data width per beat.
- `TIMEOUT_CYC`, 1024: idle-beat limit; used only when the watchdog macro is defined.

- `clk`  in  1  single clock for all logic.
- `rstn`  in  1  asynchronous, active-low reset.
- `channel_enable`  in  NUM_CH  arbitration mask, registered once internally before use.
- `s_axis_tdata`  in  NUM_CH*DATA_W  channel i on bits [i*DATA_W +: DATA_W].
- `s_axis_tvalid`  in  NUM_CH  per-channel valid.
- `s_axis_tlast`  in  NUM_CH  per-channel end of packet.
- `s_axis_tready`  out  NUM_CH  per-channel ready; at most one bit is high.
- `m_axis_tdata`  out  DATA_W  merged data.
- `m_axis_tvalid`  out  1  merged valid.
- `m_axis_tlast`  out  1  merged end of packet.
- `m_axis_tuser`  out  4  source channel index of the current beat.
- `m_axis_tready`  in  1  downstream ready.
- `timeout_flag`  out  NUM_CH  sticky per-channel watchdog flag.

## Operation
- FSM states:
  - IDLE: no grant. Requests are `s_axis_tvalid & channel_enable_q`. If any request exists, pick the first requester strictly after `last_grant`, wrapping NUM_CH-1 to 0. Register the winner as `grant` and `last_grant`, then go to LOCKED.
  - LOCKED: `s_axis_tready[grant]` is 1 while the buffer holds fewer than 2 entries; all other `s_axis_tready` bits are 0.
    - Each accepted beat pushes {data, last, grant} into the buffer.
    - Accepting a beat with `tlast`=1 returns the FSM to IDLE in the next cycle.
- Clearing `channel_enable` for a locked channel does not break the lock; the packet runs to `tlast`. Disabled channels are never granted.
- Output buffer: 2-entry FIFO. `m_axis_*` are driven from its head; `m_axis_tvalid` = not empty.
  - Simultaneous push and pop with 1 entry held: occupancy stays 1 and data order is preserved.
  - Beats leave in acceptance order. `m_axis_tdata` and `m_axis_tuser` hold stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- Reset, asserted at any time, including mid-packet:
  - FSM goes to IDLE, buffer empties, `last_grant` = NUM_CH-1 so channel 0 wins first.
  - All outputs go to 0 and `timeout_flag` is cleared.
  - Any partial packet is discarded; nothing is replayed.

## Timing
- The `channel_enable` mask takes effect 1 cycle after it changes.
- Arbitration costs 1 cycle. The first `s_axis_tready` is high in the cycle after the grant decision.
- Latency from beat acceptance to `m_axis_tvalid` is 1 cycle. A first beat presented in IDLE therefore appears on `m_axis` at cycle +2.
- Within a packet, throughput is 1 beat/cycle when `m_axis_tready`=1.
- Between packets there is one bubble cycle (IDLE).
- `s_axis_tready` is a pure function of registered state, with no combinational path from `m_axis_tready`.

## Configuration
- `AXIS_COLLECTOR_TIMEOUT_EN` defined:
  - In LOCKED, a 16-bit counter increments on each cycle in which `s_axis_tvalid[grant]`=0. It clears on any accepted beat.
  - When the counter reaches `TIMEOUT_CYC`:
    - Set `timeout_flag[grant]`.
    - Push one beat {data=0, last=1, user=grant} when the buffer has room, closing the packet; otherwise wait until room exists.
    - Return to IDLE.
  - `timeout_flag` clears only on reset.
- Not defined: no counter exists, the lock is held indefinitely, and `timeout_flag` is tied to 0.

## Test plan
- **Single channel:** after reset, ch3 sends a 4-beat packet (data 0x10..0x13, last on beat 4) with `m_axis_tready`=1 -> `m_axis` carries the 4 beats in order at cycles +2..+5, tuser=3, tlast only on 0x13.
- **Round-robin fairness:** ch0, ch5 and ch15 request continuously with 2-beat packets -> grant order is 0,5,15,0,5,…, with one idle cycle between packets and no interleaving inside a packet.
- **Backpressure:** `m_axis_tready` held 0 during an 8-beat packet -> exactly 2 beats are accepted; after ready rises, all 8 emerge in order with no loss or duplication, and data is stable while stalled.
- **Enable masking:** ch2 is disabled with tvalid=1 while ch7 is enabled -> only ch7 is served and `s_axis_tready[2]` stays 0. Disabling ch7 mid-packet still completes its packet.
- **Reset mid-packet:** `rstn` pulses low after beat 2 of 5 -> all outputs read 0 immediately, and the next grant goes to channel 0 if it is requesting.
- **Timeout (macro defined):** ch9 is locked, then tvalid drops for 1024 cycles -> `timeout_flag[9]`=1, a zero beat with tlast=1 and tuser=9 is emitted, and the FSM returns to IDLE.
